// File: rtl/superscalar_iqueue.sv
// Multi-lane circular instruction queue between fetch and rename.
// Up to WIDTH entries enqueue and dequeue per cycle; read lanes are first-word-fall-through.
module superscalar_iqueue #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned WIDTH      = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned TW = $clog2(WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            enq_valid,
    input  logic [WIDTH*DATA_WIDTH-1:0] enq_data,
    output logic                        enq_ready,
    output logic [WIDTH-1:0]            deq_valid,
    output logic [WIDTH*DATA_WIDTH-1:0] deq_data,
    input  logic [TW-1:0]               deq_take,
    output logic [CW-1:0]               count,
    output logic                        empty,
    output logic                        full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] used;
    logic [CW-1:0] free;
    logic [TW-1:0] n_enq;
    logic [TW-1:0] n_avail;
    logic [TW-1:0] n_deq;
    logic          run;
    logic          we   [WIDTH];
    logic [AW-1:0] widx [WIDTH];
    logic [AW-1:0] ridx;

    // Extra pointer bit distinguishes full from empty.
    assign used  = wptr_q - rptr_q;
    assign count = CW'(used);
    assign free  = CW'(DEPTH) - count;
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Only whole lane groups are accepted, so readiness needs room for WIDTH entries.
    assign enq_ready = (free >= CW'(WIDTH));

    assign n_avail = (count > CW'(WIDTH)) ? TW'(WIDTH) : TW'(count);
    assign n_deq   = (deq_take > n_avail) ? n_avail : deq_take;

    // Lanes past the first idle lane are ignored to keep program order contiguous.
    always_comb begin
        n_enq = '0;
        run   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (run && enq_valid[i]) begin
                n_enq = n_enq + TW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            we[i]   = enq_ready && !flush && (TW'(i) < n_enq);
            widx[i] = wptr_q[AW-1:0] + AW'(i);
        end
    end

    always_comb begin
        deq_data  = '0;
        deq_valid = '0;
        ridx      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ridx                                    = rptr_q[AW-1:0] + AW'(i);
            deq_data[i*DATA_WIDTH +: DATA_WIDTH]    = mem_q[ridx];
            deq_valid[i]                            = (TW'(i) < n_avail);
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (enq_ready) begin
                wptr_d = wptr_q + PW'(n_enq);
            end
            rptr_d = rptr_q + PW'(n_deq);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is intentionally left unreset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (we[i]) begin
                mem_q[widx[i]] <= enq_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_superscalar_iqueue.sv
// Scoreboard bench for superscalar_iqueue: a queue-based model predicts post-edge outputs,
// a monitor compares them one cycle at a time.
module tb_superscalar_iqueue;

    localparam int DW = 64;
    localparam int D  = 16;
    localparam int W  = 2;

    logic            clk;
    logic            rst;
    logic            flush;
    logic [W-1:0]    enq_valid;
    logic [W*DW-1:0] enq_data;
    logic            enq_ready;
    logic [W-1:0]    deq_valid;
    logic [W*DW-1:0] deq_data;
    logic [1:0]      deq_take;
    logic [4:0]      count;
    logic            empty;
    logic            full;

    superscalar_iqueue #(
        .DATA_WIDTH(DW),
        .DEPTH     (D),
        .WIDTH     (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .enq_valid(enq_valid),
        .enq_data (enq_data),
        .enq_ready(enq_ready),
        .deq_valid(deq_valid),
        .deq_data (deq_data),
        .deq_take (deq_take),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    typedef struct {
        int          cnt;
        logic        rdy;
        logic        emp;
        logic        ful;
        logic [1:0]  vld;
        logic [63:0] d0;
        logic [63:0] d1;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mdl[$];
    int          tests = 0;
    int          fails = 0;
    logic [63:0] seq = 64'h100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and record what the queue should show after the edge.
    task automatic drive(input logic [1:0] v, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] take, input logic fl);
        int   n_e;
        int   n_a;
        int   n_d;
        bit   rdy;
        exp_t e;
        @(negedge clk);
        enq_valid = v;
        enq_data  = {b, a};
        deq_take  = take;
        flush     = fl;
        rdy = (D - mdl.size()) >= W;
        n_e = 0;
        for (int i = 0; i < W; i++) begin
            if (v[i] && n_e == i) n_e++;
        end
        n_a = (mdl.size() < W) ? mdl.size() : W;
        n_d = (int'(take) > n_a) ? n_a : int'(take);
        if (fl) begin
            mdl.delete();
        end else begin
            repeat (n_d) void'(mdl.pop_front());
            if (rdy) begin
                if (n_e > 0) mdl.push_back(a);
                if (n_e > 1) mdl.push_back(b);
            end
        end
        e.cnt = mdl.size();
        e.rdy = (D - mdl.size()) >= W;
        e.emp = (mdl.size() == 0);
        e.ful = (mdl.size() == D);
        e.vld = (mdl.size() >= 2) ? 2'b11 : ((mdl.size() == 1) ? 2'b01 : 2'b00);
        e.d0  = (mdl.size() > 0) ? mdl[0] : 64'h0;
        e.d1  = (mdl.size() > 1) ? mdl[1] : 64'h0;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", 64'(count), 64'(e.cnt));
            chk("enq_ready", 64'(enq_ready), 64'(e.rdy));
            chk("empty", 64'(empty), 64'(e.emp));
            chk("full", 64'(full), 64'(e.ful));
            chk("deq_valid", 64'(deq_valid), 64'(e.vld));
            if (e.vld[0]) chk("deq_data0", deq_data[63:0], e.d0);
            if (e.vld[1]) chk("deq_data1", deq_data[127:64], e.d1);
        end
    end

    task automatic reset_check(input string tag);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_ready"}, 64'(enq_ready), 64'd1);
        chk({tag, "_valid"}, 64'(deq_valid), 64'd0);
    endtask

    task automatic idle();
        drive(2'b00, 64'h0, 64'h0, 2'd0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        enq_valid = '0;
        enq_data  = '0;
        deq_take  = '0;
        #12;
        reset_check("por");
        @(negedge clk);
        rst = 1'b0;

        // Basic two-lane enqueue, partial dequeue.
        drive(2'b11, 64'hA, 64'hB, 2'd0, 1'b0);
        drive(2'b00, 64'h0, 64'h0, 2'd1, 1'b0);
        idle();

        // Fill to full, then hold enq_valid against a full queue.
        drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0);
        for (int i = 0; i < 9; i++) begin
            drive(2'b11, seq, seq + 1, 2'd0, 1'b0);
            seq += 2;
        end
        idle();

        // Non-prefix enqueue, then drain with an over-large take.
        drive(2'b00, 64'h0, 64'h0, 2'd0, 1'b1);
        drive(2'b01, seq, 64'h0, 2'd0, 1'b0);
        seq += 1;
        drive(2'b10, seq, seq + 1, 2'd0, 1'b0);
        drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0);
        drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0);

        // Steady-state streaming across the storage wrap point.
        drive(2'b11, seq, seq + 1, 2'd0, 1'b0);
        seq += 2;
        for (int i = 0; i < 40; i++) begin
            drive(2'b11, seq, seq + 1, 2'd2, 1'b0);
            seq += 2;
        end

        // Build count=5, then flush while enqueuing and dequeuing.
        drive(2'b00, 64'h0, 64'h0, 2'd0, 1'b1);
        drive(2'b11, seq, seq + 1, 2'd0, 1'b0);
        drive(2'b11, seq + 2, seq + 3, 2'd0, 1'b0);
        drive(2'b01, seq + 4, 64'h0, 2'd0, 1'b0);
        drive(2'b11, 64'hDEAD, 64'hBEEF, 2'd2, 1'b1);
        seq += 5;
        drive(2'b01, seq, 64'h0, 2'd0, 1'b0);
        seq += 1;
        idle();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom_range(0, 3)), seq, seq + 1, 2'($urandom_range(0, 2)),
                  ($urandom_range(0, 39) == 0));
            seq += 2;
        end
        idle();

        // Asynchronous reset mid-cycle, checked before any clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        mdl.delete();
        #1;
        reset_check("async");
        @(negedge clk);
        rst = 1'b0;
        drive(2'b11, seq, seq + 1, 2'd0, 1'b0);
        seq += 2;
        for (int i = 0; i < 60; i++) begin
            drive(2'($urandom_range(0, 3)), seq, seq + 1, 2'($urandom_range(0, 2)), 1'b0);
            seq += 2;
        end
        idle();

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
